and2: RTL and testbench



---
 rtl/and2_pkg.sv | 10 +
 rtl/and2_sat_cnt.sv | 23 ++
 rtl/and2.sv | 56 +++++
 tb/tb_and2.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/and2_pkg.sv
// Shared constants and types for the and2 cell.
// The optional hit counter is enabled by defining AND2_STATS_EN.
package and2_pkg;

   localparam int DEF_WIDTH = 1;
   localparam int DEF_CNT_W = 16;

   typedef logic [DEF_CNT_W-1:0] hit_cnt_t;

endpackage : and2_pkg

// File: rtl/and2_sat_cnt.sv
// Saturating up-counter: advances on each enabled edge and sticks at all-ones.
// Instantiated by and2 only when AND2_STATS_EN is defined.
module and2_sat_cnt
   import and2_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule : and2_sat_cnt

// File: rtl/and2.sv
// Two-input AND cell: combinational product and reductions plus an enabled register copy.
// Defining AND2_STATS_EN adds the saturating all-ones hit counter port hit_cnt.
module and2
   import and2_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   output logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] y_q,
   output logic             y_all,
   output logic             y_any
`ifdef AND2_STATS_EN
   ,
   output logic [CNT_W-1:0] hit_cnt
`endif
);

   if (WIDTH < 1) begin : g_bad_width
      $error("and2: WIDTH must be >= 1");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("and2: CNT_W must be >= 1");
   end

   // Pure continuous logic so gate-level benches see results without any clock.
   assign y     = a & b;
   assign y_all = &y;
   assign y_any = |y;

   // NOTE: async reset clears the flop immediately; release takes effect at the next rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q <= '0;
      end else if (en) begin
         y_q <= y;
      end
   end

`ifdef AND2_STATS_EN
   and2_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_sat_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (en & y_all),
      .cnt   (hit_cnt)
   );
`endif

endmodule : and2

// File: tb/tb_and2.sv
// Self-checking bench for and2: WIDTH=8 clocked instance plus WIDTH=1 truth-table instance.
// Compile with AND2_STATS_EN defined to also check the saturating hit counter (CNT_W=2).
module tb_and2;

   localparam int W    = 8;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] a, b, y, y_q;
   logic         en, y_all, y_any;
   logic         a1, b1, y1, y1_q, en1, y1_all, y1_any;
`ifdef AND2_STATS_EN
   logic [CW-1:0] hit_cnt, hit_cnt1;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: last loaded product and number of all-ones loads (saturated).
   logic [W-1:0] m_q;
   int           m_cnt;

   and2 #(.WIDTH(W), .CNT_W(CW)) u_dut (
      .y(y), .a(a), .b(b), .clk(clk), .rst_n(rst_n), .en(en),
      .y_q(y_q), .y_all(y_all), .y_any(y_any)
`ifdef AND2_STATS_EN
      , .hit_cnt(hit_cnt)
`endif
   );

   and2 #(.WIDTH(1), .CNT_W(CW)) u_dut1 (
      .y(y1), .a(a1), .b(b1), .clk(clk), .rst_n(rst_n), .en(en1),
      .y_q(y1_q), .y_all(y1_all), .y_any(y1_any)
`ifdef AND2_STATS_EN
      , .hit_cnt(hit_cnt1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_comb(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb);
      int unsigned p;
      p = 0;
      for (int i = 0; i < W; i++) begin
         if (ta[i] == 1'b1 && tb[i] == 1'b1) p += (1 << i);
      end
      check({tag, ".y"},     32'(y),     p);
      check({tag, ".y_all"}, 32'(y_all), 32'(p == 255));
      check({tag, ".y_any"}, 32'(y_any), 32'(p != 0));
   endtask

   // One clocked transaction: drive at negedge, check comb, model the edge, check state.
   task automatic cycle(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ten);
      @(negedge clk);
      a = ta; b = tb; en = ten;
      #1;
      check_comb(tag, ta, tb);
      @(posedge clk);
      if (ten) begin
         m_q = ta & tb;
         if (m_q == 8'hFF && m_cnt < CMAX) m_cnt++;
      end
      #1;
      check({tag, ".y_q"}, 32'(y_q), 32'(m_q));
`ifdef AND2_STATS_EN
      check({tag, ".hit_cnt"}, 32'(hit_cnt), 32'(m_cnt));
`endif
   endtask

   initial begin
      logic [1:0] tt_in [4];
      logic       tt_exp [4];
      int         sat_exp [5];
      logic [W-1:0] ra, rb;
      logic         ren;

      tt_in  = '{2'b00, 2'b10, 2'b01, 2'b11};
      tt_exp = '{1'b0, 1'b0, 1'b0, 1'b1};
      sat_exp = '{1, 2, 3, 3, 3};

      rst_n = 1'b0; en = 1'b0; a = '0; b = '0;
      en1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      m_q = '0; m_cnt = 0;

      // WIDTH=1 truth table, 1 ns steps, no clock edge involved.
      for (int i = 0; i < 4; i++) begin
         a1 = tt_in[i][1];
         b1 = tt_in[i][0];
         #1;
         check($sformatf("tt%0d.y", i), 32'(y1), 32'(tt_exp[i]));
      end

      // Reset state, and combinational outputs follow inputs during reset.
      check("rst.y_q", 32'(y_q), 0);
`ifdef AND2_STATS_EN
      check("rst.hit_cnt", 32'(hit_cnt), 0);
`endif
      a = 8'hF0; b = 8'h3C;
      #1;
      check_comb("rst_comb", 8'hF0, 8'h3C);

      // Release reset between edges with en=1 already set: the next edge loads.
      @(negedge clk);
      rst_n = 1'b1; en = 1'b1;
      @(posedge clk);
      #1;
      m_q = 8'h30;
      check("release.y_q", 32'(y_q), 32'h30);

      // Directed F0 & 3C load.
      cycle("f0_3c", 8'hF0, 8'h3C, 1'b1);

      // Hold: load FF, then en=0 with a changed to 00 for three cycles.
      cycle("hold_ld", 8'hFF, 8'hFF, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle($sformatf("hold%0d", i), 8'h00, 8'hFF, 1'b0);
         check($sformatf("hold%0d.const", i), 32'(y_q), 32'hFF);
      end

      // Asynchronous reset between edges.
      cycle("pre_arst", 8'hF0, 8'h3C, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      m_q = '0; m_cnt = 0;
      check("arst.y_q", 32'(y_q), 0);
      check("arst.y", 32'(y), 32'h30);
`ifdef AND2_STATS_EN
      check("arst.hit_cnt", 32'(hit_cnt), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Saturation: five all-ones loads, then non-all-ones and disabled loads.
      for (int i = 0; i < 5; i++) begin
         cycle($sformatf("sat%0d", i), 8'hFF, 8'hFF, 1'b1);
`ifdef AND2_STATS_EN
         check($sformatf("sat%0d.table", i), 32'(hit_cnt), 32'(sat_exp[i]));
`endif
      end
      cycle("sat_miss", 8'hFE, 8'hFF, 1'b1);
      cycle("sat_dis",  8'hFF, 8'hFF, 1'b0);

      // Randomised traffic, biased towards all-ones products.
      rst_n = 1'b0;
      #1;
      m_q = '0; m_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         ra  = W'($urandom);
         rb  = W'($urandom);
         ren = 1'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            ra = '1; rb = '1;
         end
         cycle($sformatf("rnd%0d", i), ra, rb, ren);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_and2
